// File: rtl/bram_fifo_pkg.sv
// Shared width helpers for the bram_fifo block.
//   cnt_width(depth) : bits needed to hold a count in 0..depth
//   ptr_width(depth) : bits needed to address depth words
package bram_fifo_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/bram_fifo_bram.sv
// Simple dual-port block RAM with a registered read port.
//   clk_i, rst_i       : clock, synchronous active-high reset (read register only)
//   wr_en/wr_addr/data_i : write port
//   rd_en/rd_addr       : read port; data_o updates one edge after rd_en
//   data_o              : registered read data, holds while rd_en is low
module bram #(
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_DEPTH  = 16,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [RAM_WIDTH-1:0]  data_i,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [RAM_WIDTH-1:0]  data_o
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    // Array contents are never reset so the memory maps onto a plain block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o <= '0;
        end else if (rd_en) begin
            data_o <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bram_fifo.sv
// Single-clock FIFO controller around a registered-read block RAM.
//   clk_i, rst_i, flush_i          : clock, sync active-high reset, sync clear
//   wr_valid_i/wr_ready_o/wr_data_i : input stream
//   rd_valid_o/rd_ready_i/rd_data_o : output stream, rd_data_o comes straight from the RAM
//   count_o                         : words held, including the one on the output
//   full_o/empty_o/almost_full_o/almost_empty_o : status from the registered count
module bram_fifo
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    output logic                         rd_valid_o,
    input  logic                         rd_ready_i,
    output logic [DATA_WIDTH-1:0]        rd_data_o,
    output logic [cnt_width(DEPTH)-1:0]  count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    // Words in the RAM not yet read out; the word on the output is tracked by out_valid.
    logic [CNT_W-1:0] mem_count;
    logic             out_valid;

    logic clear;
    logic wr_accept;
    logic pop;
    logic rd_issue;

    assign clear     = rst_i || flush_i;
    assign wr_accept = wr_valid_i && wr_ready_o && !clear;
    assign pop       = out_valid && rd_ready_i;
    // mem_count excludes this cycle's write, so a read never hits the address being written.
    assign rd_issue  = (mem_count != '0) && (!out_valid || pop) && !clear;

    always_ff @(posedge clk_i) begin
        if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_accept, rd_issue})
                2'b10:   mem_count <= mem_count + CNT_W'(1);
                2'b01:   mem_count <= mem_count - CNT_W'(1);
                default: mem_count <= mem_count;
            endcase
            if (rd_issue) begin
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign rd_valid_o     = out_valid;
    assign count_o        = mem_count + CNT_W'(out_valid);
    assign wr_ready_o     = count_o < CNT_W'(DEPTH);
    assign full_o         = count_o == CNT_W'(DEPTH);
    assign empty_o        = count_o == '0;
    assign almost_full_o  = count_o >= CNT_W'(AF_LEVEL);
    assign almost_empty_o = count_o <= CNT_W'(AE_LEVEL);

    bram #(
        .RAM_WIDTH (DATA_WIDTH),
        .RAM_DEPTH (DEPTH),
        .ADDR_WIDTH(PTR_W)
    ) u_bram (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .wr_en  (wr_accept),
        .wr_addr(wr_ptr),
        .data_i (wr_data_i),
        .rd_en  (rd_issue),
        .rd_addr(rd_ptr),
        .data_o (rd_data_o)
    );

endmodule
